// File: rtl/apb_spi_fifo_master.sv
// APB-programmable SPI master with TX/RX FIFOs.
// Purpose : frames words from the TX FIFO onto mosi_o/sclk_o/ss_o and
//           collects the received words into the RX FIFO.
// Ports   : PCLK/PRESET_n       - clock, synchronous active-low reset
//           PSEL_i..PWDATA_i    - APB requester side (zero wait states)
//           PRDATA_o/PREADY_o/PSLVERR_o - APB completer responses
//           miso_i/mosi_o/sclk_o/ss_o   - SPI bus (ss_o active-low)
//           spi_interrupt_request_o     - level interrupt
module apb_spi_fifo_master #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_SS     = 2
) (
  input  logic              PCLK,
  input  logic              PRESET_n,
  input  logic              PSEL_i,
  input  logic              PENABLE_i,
  input  logic              PWRITE_i,
  input  logic [2:0]        PADDR_i,
  input  logic [DATA_W-1:0] PWDATA_i,
  output logic [DATA_W-1:0] PRDATA_o,
  output logic              PREADY_o,
  output logic              PSLVERR_o,
  input  logic              miso_i,
  output logic              mosi_o,
  output logic              sclk_o,
  output logic [NUM_SS-1:0] ss_o,
  output logic              spi_interrupt_request_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(2 * DATA_W);
  localparam logic [HW-1:0] LAST_HALF = HW'(2 * DATA_W - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL} state_t;
  state_t state, state_nxt;

  logic [4:0]        ctrl;
  logic [DATA_W-1:0] ssel, baud;
  logic              act_cpol, act_cpha, act_lsbfe;
  logic [DATA_W-1:0] act_ssel, act_baud;
  logic [DATA_W-1:0] tmr;
  logic [HW-1:0]     half;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]       tx_wp, tx_rp, rx_wp, rx_rp;
  logic              rx_ovf;

  logic tx_full, tx_empty, rx_full, rx_empty, busy;
  assign tx_empty = (tx_wp == tx_rp);
  assign rx_empty = (rx_wp == rx_rp);
  assign tx_full  = ((tx_wp - tx_rp) == FULL_CNT);
  assign rx_full  = ((rx_wp - rx_rp) == FULL_CNT);
  assign busy     = (state != S_IDLE);

  // APB decode: every access completes in its access phase
  logic access, unmapped, err, ok_wr, ok_rd, tx_push, rx_pop, ovf_clr;
  assign access   = PSEL_i & PENABLE_i;
  assign unmapped = (PADDR_i == 3'd4) | (PADDR_i == 3'd6) | (PADDR_i == 3'd7);
  assign err      = access & (unmapped
                  | ((PADDR_i == 3'd5) &  PWRITE_i & tx_full)
                  | ((PADDR_i == 3'd5) & ~PWRITE_i & rx_empty));
  assign ok_wr    = access &  PWRITE_i & ~err;
  assign ok_rd    = access & ~PWRITE_i & ~err;
  assign tx_push  = ok_wr & (PADDR_i == 3'd5);
  assign rx_pop   = ok_rd & (PADDR_i == 3'd5);
  assign ovf_clr  = ok_wr & (PADDR_i == 3'd3) & PWDATA_i[5];

  assign PREADY_o  = access & PRESET_n;
  assign PSLVERR_o = err & PRESET_n;

  always_comb begin
    PRDATA_o = '0;
    if (ok_rd && PRESET_n) begin
      case (PADDR_i)
        3'd0:    PRDATA_o = DATA_W'(ctrl);
        3'd1:    PRDATA_o = ssel;
        3'd2:    PRDATA_o = baud;
        3'd3:    PRDATA_o = DATA_W'({rx_ovf, busy, rx_empty, rx_full, tx_empty, tx_full});
        3'd5:    PRDATA_o = rx_mem[rx_rp[AW-1:0]];
        default: PRDATA_o = '0;
      endcase
    end
  end

  // Frame engine next-state and SCLK edge events
  logic tmr_done, tx_pop, frame_done, enter_half, leading, do_sample, do_shift, rx_store;
  logic [HW-1:0] new_half;
  assign tmr_done = (tmr == act_baud);

  always_comb begin
    state_nxt  = state;
    tx_pop     = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE:  if (ctrl[0] && !tx_empty) begin
                 state_nxt = S_LEAD;
                 tx_pop    = 1'b1;
               end
      S_LEAD:  if (tmr_done) state_nxt = S_SHIFT;
      S_SHIFT: if (tmr_done && half == LAST_HALF) state_nxt = S_TRAIL;
      S_TRAIL: if (tmr_done) begin
                 state_nxt  = S_IDLE;
                 frame_done = 1'b1;
               end
      default: state_nxt = S_IDLE;
    endcase
  end

  // An SCLK edge happens when a new half-period starts; even halves start
  // with the leading edge. With CPHA=1 the first leading edge only presents
  // the bit already loaded, so it must not shift.
  assign enter_half = ((state == S_LEAD) && tmr_done)
                    | ((state == S_SHIFT) && tmr_done && (half != LAST_HALF));
  assign new_half   = (state == S_LEAD) ? '0 : half + HW'(1);
  assign leading    = ~new_half[0];
  assign do_sample  = enter_half & (act_cpha ? ~leading : leading);
  assign do_shift   = enter_half & (act_cpha ? (leading & (new_half != '0)) : ~leading);
  // A same-cycle APB pop frees the slot, so a full RX still accepts the word.
  assign rx_store   = frame_done & (~rx_full | rx_pop);

  // Control state
  always_ff @(posedge PCLK) begin
    if (!PRESET_n) begin
      state     <= S_IDLE;
      ctrl      <= '0;
      ssel      <= '0;
      baud      <= '0;
      act_cpol  <= 1'b0;
      act_cpha  <= 1'b0;
      act_lsbfe <= 1'b0;
      act_ssel  <= '0;
      act_baud  <= '0;
      tmr       <= '0;
      half      <= '0;
      tx_wp     <= '0;
      tx_rp     <= '0;
      rx_wp     <= '0;
      rx_rp     <= '0;
      rx_ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ok_wr && PADDR_i == 3'd0) ctrl <= PWDATA_i[4:0];
      if (ok_wr && PADDR_i == 3'd1) ssel <= PWDATA_i;
      if (ok_wr && PADDR_i == 3'd2) baud <= PWDATA_i;
      // Frame settings are frozen at LEAD entry so mid-frame writes wait.
      if (tx_pop) begin
        act_cpol  <= ctrl[1];
        act_cpha  <= ctrl[2];
        act_lsbfe <= ctrl[3];
        act_ssel  <= ssel;
        act_baud  <= baud;
      end
      if (state == S_IDLE || tmr_done) tmr <= '0;
      else                             tmr <= tmr + DATA_W'(1);
      if (state == S_LEAD)                 half <= '0;
      else if (state == S_SHIFT && tmr_done) half <= half + HW'(1);
      if (tx_push)  tx_wp <= tx_wp + 1'b1;
      if (tx_pop)   tx_rp <= tx_rp + 1'b1;
      if (rx_store) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)   rx_rp <= rx_rp + 1'b1;
      if (frame_done && !rx_store) rx_ovf <= 1'b1;
      else if (ovf_clr)            rx_ovf <= 1'b0;
    end
  end

  // Datapath: FIFO storage and shift registers
  always_ff @(posedge PCLK) begin
    if (tx_push)  tx_mem[tx_wp[AW-1:0]] <= PWDATA_i;
    if (rx_store) rx_mem[rx_wp[AW-1:0]] <= rx_sr;
    if (tx_pop)
      tx_sr <= tx_mem[tx_rp[AW-1:0]];
    else if (do_shift)
      tx_sr <= act_lsbfe ? (tx_sr >> 1) : (tx_sr << 1);
    if (do_sample)
      rx_sr <= act_lsbfe ? {miso_i, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso_i};
  end

  // SPI pins
  always_comb begin
    ss_o = '1;
    if (state != S_IDLE) begin
      for (int i = 0; i < NUM_SS; i++) begin
        if (act_ssel == DATA_W'(i)) ss_o[i] = 1'b0;
      end
    end
  end

  always_comb begin
    case (state)
      S_IDLE:  sclk_o = ctrl[1];
      S_SHIFT: sclk_o = act_cpol ^ ~half[0];
      default: sclk_o = act_cpol;
    endcase
  end

  assign mosi_o = busy & (act_lsbfe ? tx_sr[0] : tx_sr[DATA_W-1]);
  assign spi_interrupt_request_o = ctrl[4] & (~rx_empty | rx_ovf | (tx_empty & ~busy));

endmodule

// File: tb/tb_apb_spi_fifo_master.sv
// Directed bench for apb_spi_fifo_master (DATA_W=8, FIFO_DEPTH=4, NUM_SS=2).
module tb_apb_spi_fifo_master;

  logic       PCLK = 1'b0;
  logic       PRESET_n = 1'b0;
  logic       PSEL_i = 1'b0, PENABLE_i = 1'b0, PWRITE_i = 1'b0;
  logic [2:0] PADDR_i = '0;
  logic [7:0] PWDATA_i = '0;
  logic [7:0] PRDATA_o;
  logic       PREADY_o, PSLVERR_o;
  logic       miso_i, mosi_o, sclk_o;
  logic [1:0] ss_o;
  logic       irq;

  logic loopback = 1'b0;
  logic miso_val = 1'b0;
  assign miso_i = loopback ? mosi_o : miso_val;

  apb_spi_fifo_master #(.DATA_W(8), .FIFO_DEPTH(4), .NUM_SS(2)) dut (
    .PCLK(PCLK), .PRESET_n(PRESET_n),
    .PSEL_i(PSEL_i), .PENABLE_i(PENABLE_i), .PWRITE_i(PWRITE_i),
    .PADDR_i(PADDR_i), .PWDATA_i(PWDATA_i),
    .PRDATA_o(PRDATA_o), .PREADY_o(PREADY_o), .PSLVERR_o(PSLVERR_o),
    .miso_i(miso_i), .mosi_o(mosi_o), .sclk_o(sclk_o), .ss_o(ss_o),
    .spi_interrupt_request_o(irq)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [2:0] addr, input logic [7:0] wdata,
                     output logic [7:0] rdata, output logic err, output logic rdy);
    @(negedge PCLK);
    PSEL_i = 1'b1; PENABLE_i = 1'b0; PWRITE_i = wr; PADDR_i = addr; PWDATA_i = wdata;
    @(negedge PCLK);
    PENABLE_i = 1'b1;
    #1;
    rdata = PRDATA_o; err = PSLVERR_o; rdy = PREADY_o;
    @(posedge PCLK);
    #1;
    PSEL_i = 1'b0; PENABLE_i = 1'b0;
  endtask

  // Waits for a frame, collects mosi at the sampling edge of each bit.
  task automatic capture_frame(input logic cpol, input logic cpha,
                               output logic timeout, output logic [1:0] ss_seen,
                               output int n_lead, output logic [7:0] bits,
                               output int period, output int period_bad);
    logic prev;
    int   last_lead;
    timeout = 1'b1; ss_seen = 2'b11; n_lead = 0; bits = '0; period = 0; period_bad = 0;
    last_lead = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge PCLK);
      if (ss_o != 2'b11) begin timeout = 1'b0; break; end
    end
    if (timeout) return;
    ss_seen = ss_o;
    prev = sclk_o;
    timeout = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge PCLK);
      if (sclk_o != prev) begin
        if (sclk_o != cpol) begin
          n_lead++;
          if (last_lead >= 0) begin
            if (period == 0) period = i - last_lead;
            else if (period != i - last_lead) period_bad++;
          end
          last_lead = i;
          if (!cpha) bits = {bits[6:0], mosi_o};
        end else if (cpha) begin
          bits = {bits[6:0], mosi_o};
        end
      end
      prev = sclk_o;
      if (ss_o == 2'b11) begin timeout = 1'b0; break; end
    end
  endtask

  task automatic do_reset();
    @(negedge PCLK);
    PRESET_n = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    PRESET_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic       er, rdy, to;
    logic [1:0] ssv;
    logic [7:0] bits;
    int         nl, per, pbad;
    logic [7:0] words [5];
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    // Reset state
    repeat (3) @(negedge PCLK);
    check("rst_ss", ss_o, 2'b11);
    check("rst_sclk", sclk_o, 1'b0);
    check("rst_mosi", mosi_o, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_pready", PREADY_o, 1'b0);
    PRESET_n = 1'b1;
    apb(1'b0, 3'd3, 8'h00, rd, er, rdy);
    check("rst_status", rd, 8'h0A);
    check("pready", rdy, 1'b1);

    // Mode 0, MSB first, BAUD=1
    apb(1'b1, 3'd2, 8'h01, rd, er, rdy);
    apb(1'b1, 3'd5, 8'hA5, rd, er, rdy);
    check("m0_push_err", er, 1'b0);
    miso_val = 1'b1;
    apb(1'b1, 3'd0, 8'h01, rd, er, rdy);
    capture_frame(1'b0, 1'b0, to, ssv, nl, bits, per, pbad);
    check("m0_timeout", to, 1'b0);
    check("m0_ss", ssv, 2'b10);
    check("m0_edges", nl, 8);
    check("m0_mosi", bits, 8'hA5);
    check("m0_period", per, 4);
    check("m0_period_bad", pbad, 0);
    apb(1'b0, 3'd5, 8'h00, rd, er, rdy);
    check("m0_rx", rd, 8'hFF);
    check("m0_rx_err", er, 1'b0);

    // Mode 3, LSB first, SSEL=1
    apb(1'b1, 3'd0, 8'h0F, rd, er, rdy);
    @(negedge PCLK);
    check("m3_sclk_idle", sclk_o, 1'b1);
    apb(1'b1, 3'd1, 8'h01, rd, er, rdy);
    miso_val = 1'b0;
    apb(1'b1, 3'd5, 8'h01, rd, er, rdy);
    capture_frame(1'b1, 1'b1, to, ssv, nl, bits, per, pbad);
    check("m3_timeout", to, 1'b0);
    check("m3_ss", ssv, 2'b01);
    check("m3_edges", nl, 8);
    check("m3_mosi", bits, 8'h80);
    check("m3_period", per, 4);
    apb(1'b0, 3'd5, 8'h00, rd, er, rdy);
    check("m3_rx", rd, 8'h00);

    // TX overflow with engine disabled
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apb(1'b1, 3'd5, 8'h10 + 8'(i), rd, er, rdy);
      check($sformatf("txfill_err%0d", i), er, (i == 4) ? 1'b1 : 1'b0);
    end
    apb(1'b0, 3'd3, 8'h00, rd, er, rdy);
    check("txfull_status", rd, 8'h09);
    check("txfull_sclk", sclk_o, 1'b0);
    check("txfull_ss", ss_o, 2'b11);

    // Reset in the middle of a frame
    apb(1'b1, 3'd0, 8'h01, rd, er, rdy);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (ss_o != 2'b11) begin to = 1'b0; break; end
    end
    check("midrst_started", to, 1'b0);
    repeat (6) @(negedge PCLK);
    PRESET_n = 1'b0;
    @(negedge PCLK);
    check("midrst_ss", ss_o, 2'b11);
    check("midrst_sclk", sclk_o, 1'b0);
    check("midrst_mosi", mosi_o, 1'b0);
    PRESET_n = 1'b1;
    apb(1'b0, 3'd3, 8'h00, rd, er, rdy);
    check("midrst_status", rd, 8'h0A);

    // RX overflow through loopback, BAUD=0, IE=1
    loopback = 1'b1;
    apb(1'b1, 3'd0, 8'h11, rd, er, rdy);
    for (int i = 0; i < 5; i++) begin
      apb(1'b1, 3'd5, words[i], rd, er, rdy);
      check($sformatf("ovf_push_err%0d", i), er, 1'b0);
    end
    to = 1'b1;
    for (int i = 0; i < 300; i++) begin
      apb(1'b0, 3'd3, 8'h00, rd, er, rdy);
      if ((rd & 8'h12) == 8'h02) begin to = 1'b0; break; end
    end
    check("ovf_timeout", to, 1'b0);
    check("ovf_status", rd, 8'h26);
    check("ovf_irq", irq, 1'b1);
    for (int i = 0; i < 4; i++) begin
      apb(1'b0, 3'd5, 8'h00, rd, er, rdy);
      check($sformatf("ovf_rx%0d", i), rd, words[i]);
      check($sformatf("ovf_rx_err%0d", i), er, 1'b0);
    end
    apb(1'b0, 3'd5, 8'h00, rd, er, rdy);
    check("empty_rd_err", er, 1'b1);
    check("empty_rd_data", rd, 8'h00);
    apb(1'b1, 3'd3, 8'h20, rd, er, rdy);
    check("ovf_clr_err", er, 1'b0);
    apb(1'b0, 3'd3, 8'h00, rd, er, rdy);
    check("ovf_cleared", rd, 8'h0A);
    loopback = 1'b0;

    // Unmapped addresses and register readback
    apb(1'b1, 3'd7, 8'hFF, rd, er, rdy);
    check("unmap_wr_err", er, 1'b1);
    apb(1'b0, 3'd7, 8'h00, rd, er, rdy);
    check("unmap_rd_err", er, 1'b1);
    check("unmap_rd_data", rd, 8'h00);
    apb(1'b0, 3'd4, 8'h00, rd, er, rdy);
    check("unmap4_err", er, 1'b1);
    apb(1'b0, 3'd0, 8'h00, rd, er, rdy);
    check("ctrl_unchanged", rd, 8'h11);
    apb(1'b1, 3'd2, 8'h5A, rd, er, rdy);
    apb(1'b0, 3'd2, 8'h00, rd, er, rdy);
    check("baud_rb", rd, 8'h5A);
    apb(1'b1, 3'd0, 8'hE0, rd, er, rdy);
    apb(1'b0, 3'd0, 8'h00, rd, er, rdy);
    check("ctrl_mask", rd, 8'h00);
    check("irq_off", irq, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
